// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encoding, default sizing
// and the pointer-advance helper used when a grant is released.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int DEF_N        = 4;
   localparam int DEF_MAX_HOLD = 8;

   function automatic int next_idx(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_if #(
   parameter int N = arb_pkg::DEF_N
);
   localparam int IW = $clog2(N);

   logic [N-1:0]  req;
   logic          done;
   logic [N-1:0]  gnt;
   logic [IW-1:0] gnt_id;
   logic          busy;
   logic          timeout;
   logic          any_req;

   modport master (
      output req, done,
      input  gnt, gnt_id, busy, timeout, any_req
   );

   modport slave (
      input  req, done,
      output gnt, gnt_id, busy, timeout, any_req
   );

endinterface

// File: rtl/rr_arbiter_pick.sv
// Rotating-priority encoder: first set request at or above i_ptr, wrapping to 0.
// Purely combinational.
module rr_pick
   import arb_pkg::*;
#(
   parameter  int N  = DEF_N,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [IW-1:0] o_idx,
   output logic          o_vld
);

   logic [IW-1:0] w_pos;

   always_comb begin
      o_idx = '0;
      o_vld = 1'b0;
      w_pos = '0;
      for (int k = 0; k < N; k++) begin
         w_pos = IW'((int'(i_ptr) + k) % N);
         if (!o_vld && i_req[w_pos]) begin
            o_vld = 1'b1;
            o_idx = w_pos;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with held grants, release on done / dropped request /
// hold limit, and a combinational any-request flag.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic         clk,
   input  logic         rst,
   rr_arbiter_if.slave  bus
);

   localparam int IW = $clog2(N);
   // Counter keeps at least one bit so MAX_HOLD=0 still elaborates cleanly.
   localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;

   state_t        r_state;
   logic [IW-1:0] r_ptr;
   logic [IW-1:0] r_gnt_id;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_gnt;
   logic          r_busy;
   logic          r_timeout;

   logic [IW-1:0] w_win_idx;
   logic          w_win_vld;
   logic          w_rel_done;
   logic          w_rel_drop;
   logic          w_rel_to;
   logic          w_release;

   rr_pick #(.N(N)) u_pick (
      .i_req (bus.req),
      .i_ptr (r_ptr),
      .o_idx (w_win_idx),
      .o_vld (w_win_vld)
   );

   assign w_rel_done = bus.done;
   assign w_rel_drop = !bus.req[r_gnt_id];
   assign w_rel_to   = (MAX_HOLD > 0) && (r_cnt == CNT_LAST);
   assign w_release  = w_rel_done || w_rel_drop || w_rel_to;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_gnt_id  <= '0;
         r_cnt     <= '0;
         r_gnt     <= '0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_win_vld) begin
                  r_state  <= GRANT;
                  r_gnt    <= N'(1) << w_win_idx;
                  r_gnt_id <= w_win_idx;
                  r_busy   <= 1'b1;
                  r_cnt    <= '0;
               end
            end
            GRANT: begin
               if (w_release) begin
                  r_state   <= IDLE;
                  r_gnt     <= '0;
                  r_busy    <= 1'b0;
                  r_ptr     <= IW'(next_idx(int'(r_gnt_id), N));
                  // Only a pure hold-limit revoke is flagged.
                  r_timeout <= w_rel_to && !w_rel_done && !w_rel_drop;
               end else if (r_cnt != '1) begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.gnt_id  = r_gnt_id;
   assign bus.busy    = r_busy;
   assign bus.timeout = r_timeout;
   assign bus.any_req = |bus.req;

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that shares one downstream resource among N requesters. Each grant is held until the owner releases it, drops its request, or exceeds a hold limit. It sits between request sources and a shared resource such as an OR-combined output or a bus. It also exports the OR-reduction of all requests as a "someone wants it" flag.

## Interface
- N, default 4: number of requesters, minimum 2.
- MAX_HOLD, default 8: maximum grant length in cycles. 0 disables the timeout.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  per-requester request level.
- done  input  1  current owner releases the grant. Ignored when no grant is active.
- gnt  output  N  one-hot grant, registered.
- gnt_id  output  $clog2(N)  index of the current owner, registered. Holds the last owner while idle.
- busy  output  1  a grant is active, registered.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.
- any_req  output  1  combinational OR of all req bits.

## Operation
- Reset values: gnt=0, gnt_id=0, busy=0, timeout=0. Internal state: state=IDLE, priority pointer ptr=0, hold counter cnt=0.
- The FSM has two states: IDLE and GRANT.
- IDLE to GRANT on a clock edge when any_req=1.
  - Winner is the first set req bit scanning from ptr upward, wrapping N-1 to 0.
  - gnt is set to one-hot(winner), gnt_id=winner, busy=1, cnt=0.
- IDLE with any_req=0: no change.
- GRANT to IDLE on a clock edge when any of these holds:
  - (a) done=1;
  - (b) req[gnt_id]=0;
  - (c) MAX_HOLD>0 and cnt==MAX_HOLD-1.
- On that edge: gnt=0, busy=0, ptr=(gnt_id+1) mod N.
  - Pointer wrap: owner N-1 gives ptr=0.
- timeout=1 for exactly that cycle only for case (c) when neither (a) nor (b) holds. Release by done or by a dropped request takes precedence and produces no timeout pulse.
- In GRANT with no release, cnt increments by 1 per cycle. cnt width is $clog2(MAX_HOLD+1) and it never wraps.
- Requests from non-owners while in GRANT are ignored until the next IDLE arbitration.
- done asserted in IDLE has no effect.
- Asserting rst at any time forces all outputs and state to reset values immediately, without waiting for a clock edge. There is no partial grant after reset.

## Timing
- Grant latency: a req sampled high on edge k in IDLE gives gnt valid after edge k, i.e. one cycle.
- Release latency: done or a dropped request sampled on edge k gives gnt=0 after edge k.
- Between consecutive grants there is exactly one IDLE cycle. Sustained throughput is one grant per (hold + 1) cycles.
- Maximum grant length is MAX_HOLD cycles, counted from the first cycle gnt is high.
- any_req has zero latency. It is purely combinational from req.
- gnt and gnt_id change only on clock edges or on rst assertion.

## Structure
- Shared package arb_pkg holds:
  - state encodings IDLE=1'b0 and GRANT=1'b1;
  - default values for N and MAX_HOLD;
  - a function computing (idx+1) mod N.
- Sub-module rr_pick is natural: a combinational rotate-priority encoder. Inputs are req[N] and ptr. Outputs are winner index and valid.
- rr_arbiter owns the FSM, the pointer register, the hold counter and the output registers.

## Test plan
- Reset: assert rst mid-simulation with req=4'b1111. Required: gnt=0, gnt_id=0, busy=0, timeout=0 immediately, before any clock edge.
- Single requester: req=4'b0100 on edge 0, done pulsed on edge 3. Required:
  - gnt=4'b0100, gnt_id=2, busy=1 after edge 0;
  - gnt=0 after edge 3;
  - on the next request, the arbitration scan starts from ptr=3.
- Fairness: req=4'b1111 held, done pulsed every second GRANT cycle. Required grant order 0,1,2,3,0, with one IDLE cycle between grants.
- Wrap-around: ptr=3 with req=4'b1001. Required: grant 3 first, then grant 0 after release, never 0 first.
- Timeout, MAX_HOLD=8: req=4'b0011 held and done never asserted. Required:
  - gnt=4'b0001 for exactly 8 cycles;
  - timeout=1 on the revoke cycle only;
  - next grant 4'b0010.
- Precedence: done=1 on the same edge where cnt==MAX_HOLD-1. Required: grant released with timeout=0. Also pulse done in IDLE; required: no state change.
